// File: rtl/epu_buf_pkg.sv
// Shared types and defaults for the EPU ping-pong buffer.
// No logic; constants and the fill FSM encoding only.
// Imported by epu_buf_bank and epu_pingpong_buf.
`timescale 1ns/1ps
package epu_buf_pkg;

    localparam int EPU_BUF_DEPTH  = 2048;
    localparam int EPU_BUF_DATA_W = 32;

    // F_LOAD: accepting fill beats into the fill bank.
    // F_FULL: fill bank complete, waiting for the engine to release its bank.
    typedef enum logic [0:0] {
        F_LOAD = 1'b0,
        F_FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/ConvAcc.svh
// Shared ConvAcc encodings for the compute engine's single-port RAM request protocol.
// W_req is a single bit: WRITE_ENB requests a write and WRITE_DIS requests a read.
// Guarded so several files of a build may include it.
`ifndef CONVACC_SVH
`define CONVACC_SVH

`define WRITE_ENB 1'b1
`define WRITE_DIS 1'b0

`endif

// File: rtl/epu_buf_bank.sv
// Single-port synchronous RAM bank: one write or one read per cycle.
// Latency: write lands at the clock edge; read data registered, valid 1 cycle later.
// Backpressure: none; rdat holds its value on cycles without re.
// Ports: clk/rstn, we/re strobes, addr word index, wdat in, rdat registered out.
`timescale 1ns/1ps
module epu_buf_bank
    import epu_buf_pkg::*;
#(
    parameter int DATA_W = EPU_BUF_DATA_W,
    parameter int DEPTH  = EPU_BUF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdat,
    output logic [DATA_W-1:0] rdat
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array is never reset; contents survive rstn.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdat <= '0;
        end else if (re) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/epu_pingpong_buf.sv
// Two-bank ping-pong buffer: compute engine RAM port on one bank, stream fill into the other.
// Latency: compute read data 1 cycle after cs; swap 1 edge after (fill complete & bank released).
// Backpressure: fill_ready low while the fill bank is full and waiting for comp_done.
// Ports: clk/rstn; compute side cs/oe/addr/W_req/W_data -> R_data; fill side
// fill_valid/fill_ready/fill_data/fill_last; comp_done in; comp_valid/comp_len/buf_swap/oor_err out.
// Build option: define EPU_BUF_OOR_CHK_EN to reject compute accesses with addr >= DEPTH
// (write dropped, read returns 0, sticky oor_err); otherwise addr is truncated to IDX_W bits.
`timescale 1ns/1ps
`include "ConvAcc.svh"
module epu_pingpong_buf
    import epu_buf_pkg::*;
#(
    parameter int DATA_W = EPU_BUF_DATA_W,
    parameter int DEPTH  = EPU_BUF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              oe,
    input  logic [31:0]       addr,
    input  logic              W_req,
    input  logic [DATA_W-1:0] W_data,
    output logic [DATA_W-1:0] R_data,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_last,
    input  logic              comp_done,
    output logic              comp_valid,
    output logic [IDX_W:0]    comp_len,
    output logic              buf_swap,
    output logic              oor_err
);

    fill_state_t       state;
    logic              comp_sel;        // bank index currently owned by the compute engine
    logic [IDX_W-1:0]  fill_ptr;
    logic [IDX_W:0]    fill_cnt;
    logic              comp_done_pend;  // engine has released its bank since the last swap
    logic              rd_sel;          // bank that produced the last compute read
    logic              rd_zero;         // last compute read was rejected and returns 0

    logic              cp_wr;
    logic              cp_rd;
    logic              cp_oor;
    logic [IDX_W-1:0]  cp_idx;
    logic              fill_acc;
    logic              fill_done_beat;
    logic              swap_en;
    logic [DATA_W-1:0] rd_q;

    logic              bk_we   [2];
    logic              bk_re   [2];
    logic [IDX_W-1:0]  bk_addr [2];
    logic [DATA_W-1:0] bk_wdat [2];
    logic [DATA_W-1:0] bk_rdat [2];

    assign cp_wr  = cs & (W_req == `WRITE_ENB);
    assign cp_rd  = cs & (W_req == `WRITE_DIS);
    assign cp_idx = addr[IDX_W-1:0];

`ifdef EPU_BUF_OOR_CHK_EN
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH);

    assign cp_oor = cs & (addr >= DEPTH_LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oor_err <= 1'b0;
        end else if (cp_oor) begin
            oor_err <= 1'b1;
        end
    end
`else
    // Upper address bits are deliberately ignored: accesses alias modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W];
    assign cp_oor         = 1'b0;
    assign oor_err        = 1'b0;
`endif

    assign fill_ready     = (state == F_LOAD);
    assign fill_acc       = fill_valid & fill_ready;
    assign fill_done_beat = fill_acc & (fill_last | (fill_ptr == IDX_W'(DEPTH - 1)));
    assign swap_en        = comp_done_pend & (state == F_FULL);

    // Steer compute port to bank comp_sel and fill port to the other bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (comp_sel == 1'(b)) begin
                bk_we[b]   = cp_wr & ~cp_oor;
                bk_re[b]   = cp_rd & ~cp_oor;
                bk_addr[b] = cp_idx;
                bk_wdat[b] = W_data;
            end else begin
                bk_we[b]   = fill_acc;
                bk_re[b]   = 1'b0;
                bk_addr[b] = fill_ptr;
                bk_wdat[b] = fill_data;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        epu_buf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk  (clk),
            .rstn (rstn),
            .we   (bk_we[b]),
            .re   (bk_re[b]),
            .addr (bk_addr[b]),
            .wdat (bk_wdat[b]),
            .rdat (bk_rdat[b])
        );
    end

    // Each bank keeps its own read register; rd_sel remembers which one holds the
    // latest read so R_data stays put across a swap and across non-read cycles.
    assign rd_q   = rd_zero ? '0 : bk_rdat[rd_sel];
    assign R_data = oe ? rd_q : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= F_LOAD;
            comp_sel       <= 1'b0;
            fill_ptr       <= '0;
            fill_cnt       <= '0;
            comp_done_pend <= 1'b1;
            comp_valid     <= 1'b0;
            comp_len       <= '0;
            buf_swap       <= 1'b0;
            rd_sel         <= 1'b0;
            rd_zero        <= 1'b0;
        end else begin
            buf_swap <= swap_en;

            if (cp_rd) begin
                rd_sel  <= comp_sel;
                rd_zero <= cp_oor;
            end

            if (swap_en) begin
                // comp_done arriving with the swap is absorbed here, not re-armed.
                comp_sel       <= ~comp_sel;
                comp_len       <= fill_cnt;
                comp_valid     <= 1'b1;
                comp_done_pend <= 1'b0;
                state          <= F_LOAD;
                fill_ptr       <= '0;
            end else begin
                if (comp_done) begin
                    comp_done_pend <= 1'b1;
                end
                if (fill_acc) begin
                    fill_ptr <= fill_ptr + IDX_W'(1);
                    if (fill_done_beat) begin
                        state    <= F_FULL;
                        fill_cnt <= (IDX_W+1)'(fill_ptr) + (IDX_W+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_epu_pingpong_buf.sv
`timescale 1ns/1ps
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`define WRITE_DIS 1'b0
`endif
module tb_epu_pingpong_buf;

    localparam int DEPTH = 2048;

    logic        clk;
    logic        rstn;
    logic        cs;
    logic        oe;
    logic [31:0] addr;
    logic        W_req;
    logic [31:0] W_data;
    logic [31:0] R_data;
    logic        fill_valid;
    logic        fill_ready;
    logic [31:0] fill_data;
    logic        fill_last;
    logic        comp_done;
    logic        comp_valid;
    logic [11:0] comp_len;
    logic        buf_swap;
    logic        oor_err;

    epu_pingpong_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .cs         (cs),
        .oe         (oe),
        .addr       (addr),
        .W_req      (W_req),
        .W_data     (W_data),
        .R_data     (R_data),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_data  (fill_data),
        .fill_last  (fill_last),
        .comp_done  (comp_done),
        .comp_valid (comp_valid),
        .comp_len   (comp_len),
        .buf_swap   (buf_swap),
        .oor_err    (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: two word arrays plus the buffer-level bookkeeping.
    logic [31:0] mbank [2][DEPTH];
    int          m_sel;
    int          m_ptr;
    int          m_cnt;
    int          m_len;
    bit          m_full;
    bit          m_pend;
    bit          m_cv;
    bit          m_swap;
    bit          m_oor;
    logic [31:0] m_rdat;

    typedef struct {
        logic        cs;
        logic        wr;
        logic        oe;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        fv;
        logic [31:0] fd;
        logic        fl;
        logic        cd;
        logic [31:0] e_rdat;
        logic        e_frdy;
        logic        e_cv;
        logic [11:0] e_len;
        logic        e_swap;
        logic        e_oor;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic c, logic w, logic o, logic [31:0] a, logic [31:0] wd,
                                logic fv, logic [31:0] fd, logic fl, logic cd,
                                logic [31:0] er, logic efr, logic ecv, logic [11:0] el,
                                logic esw, logic eoor);
        vec_t v;
        v.cs = c; v.wr = w; v.oe = o; v.addr = a; v.wdat = wd;
        v.fv = fv; v.fd = fd; v.fl = fl; v.cd = cd;
        v.e_rdat = er; v.e_frdy = efr; v.e_cv = ecv; v.e_len = el;
        v.e_swap = esw; v.e_oor = eoor;
        return v;
    endfunction

    function automatic logic [31:0] va(int i); return 32'h1111_0000 + 32'(i); endfunction
    function automatic logic [31:0] vb(int i); return 32'h2222_0000 + 32'(i); endfunction
    function automatic logic [31:0] vc(int i); return 32'hC000_0000 + 32'(i); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_ptr = 0; m_cnt = 0; m_len = 0;
        m_full = 0; m_pend = 1; m_cv = 0; m_swap = 0; m_oor = 0;
        m_rdat = '0;
    endtask

    task automatic model_step();
        bit swap;
        int cur;
        int oth;
        int idx;
        swap = m_pend && m_full;
        cur  = m_sel;
        oth  = 1 - m_sel;
        if (cs) begin
`ifdef EPU_BUF_OOR_CHK_EN
            if (addr >= 32'd2048) begin
                m_oor = 1;
                if (W_req == `WRITE_DIS) m_rdat = '0;
            end else begin
                idx = int'(addr % 32'd2048);
                if (W_req == `WRITE_ENB) mbank[cur][idx] = W_data;
                else                     m_rdat = mbank[cur][idx];
            end
`else
            idx = int'(addr % 32'd2048);
            if (W_req == `WRITE_ENB) mbank[cur][idx] = W_data;
            else                     m_rdat = mbank[cur][idx];
`endif
        end
        if (fill_valid && !m_full) begin
            mbank[oth][m_ptr] = fill_data;
            m_ptr++;
            if (fill_last || m_ptr == DEPTH) begin
                m_full = 1;
                m_cnt  = m_ptr;
            end
        end
        if (swap) begin
            m_sel = oth; m_len = m_cnt; m_cv = 1; m_pend = 0; m_full = 0; m_ptr = 0;
        end else if (comp_done) begin
            m_pend = 1;
        end
        m_swap = swap;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_r;
        exp_r = oe ? m_rdat : 32'd0;
        // Words never written have no defined value; only their read is skipped.
        if (^exp_r !== 1'bx) chk({tag, ".R_data"}, R_data, exp_r);
        chk({tag, ".fill_ready"}, 32'(fill_ready), 32'(!m_full));
        chk({tag, ".comp_valid"}, 32'(comp_valid), 32'(m_cv));
        chk({tag, ".comp_len"},   32'(comp_len),   32'(m_len));
        chk({tag, ".buf_swap"},   32'(buf_swap),   32'(m_swap));
        chk({tag, ".oor_err"},    32'(oor_err),    32'(m_oor));
    endtask

    task automatic chk_reset_consts(input string tag);
        chk({tag, ".R_data"},     R_data,           32'd0);
        chk({tag, ".fill_ready"}, 32'(fill_ready), 32'd1);
        chk({tag, ".comp_valid"}, 32'(comp_valid), 32'd0);
        chk({tag, ".comp_len"},   32'(comp_len),   32'd0);
        chk({tag, ".buf_swap"},   32'(buf_swap),   32'd0);
        chk({tag, ".oor_err"},    32'(oor_err),    32'd0);
    endtask

    task automatic idle();
        cs = 1'b0; W_req = `WRITE_DIS; addr = '0; W_data = '0; oe = 1'b1;
        fill_valid = 1'b0; fill_data = '0; fill_last = 1'b0; comp_done = 1'b0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        model_reset();
        #1;
        chk_reset_consts(tag);
        check_all(tag);
        #2;
        rstn = 1'b1;
    endtask

    task automatic rd(input int a);
        idle(); cs = 1'b1; W_req = `WRITE_DIS; addr = 32'(a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [31:0] alias_exp;
        logic        oor_exp;
`ifdef EPU_BUF_OOR_CHK_EN
        alias_exp = 32'd0;
        oor_exp   = 1'b1;
`else
        alias_exp = va(0);
        oor_exp   = 1'b0;
`endif
        //              cs wr oe addr         wdat          fv fd     fl cd | rdat       frdy cv len swap oor
        tbl[0]  = mk(0, 0, 1, 0,            0,            1, va(0), 0, 0,   0,          1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0,            0,            1, va(1), 0, 0,   0,          1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0,            0,            1, va(2), 0, 0,   0,          1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0,            0,            1, va(3), 1, 0,   0,          0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0,            0,            0, 0,     0, 0,   0,          1, 1, 4, 1, 0);
        tbl[5]  = mk(1, 0, 1, 0,            0,            0, 0,     0, 0,   va(0),      1, 1, 4, 0, 0);
        tbl[6]  = mk(1, 0, 1, 1,            0,            0, 0,     0, 0,   va(1),      1, 1, 4, 0, 0);
        tbl[7]  = mk(1, 0, 1, 2,            0,            0, 0,     0, 0,   va(2),      1, 1, 4, 0, 0);
        tbl[8]  = mk(1, 0, 1, 3,            0,            0, 0,     0, 0,   va(3),      1, 1, 4, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0,            0,            0, 0,     0, 0,   va(3),      1, 1, 4, 0, 0);
        tbl[10] = mk(1, 1, 1, 7,            32'hDEADBEEF, 0, 0,     0, 0,   va(3),      1, 1, 4, 0, 0);
        tbl[11] = mk(1, 0, 1, 7,            0,            0, 0,     0, 0,   32'hDEADBEEF, 1, 1, 4, 0, 0);
        tbl[12] = mk(0, 0, 0, 0,            0,            0, 0,     0, 0,   0,          1, 1, 4, 0, 0);
        tbl[13] = mk(0, 0, 1, 0,            0,            0, 0,     0, 0,   32'hDEADBEEF, 1, 1, 4, 0, 0);
        tbl[14] = mk(1, 0, 1, 2048,         0,            0, 0,     0, 0,   alias_exp,  1, 1, 4, 0, oor_exp);
        tbl[15] = mk(0, 0, 1, 0,            0,            0, 0,     0, 0,   alias_exp,  1, 1, 4, 0, oor_exp);

        rstn = 1'b1;
        idle();
        #2;
        rstn = 1'b0;
        model_reset();
        #10;
        chk_reset_consts("reset");
        #1;
        rstn = 1'b1;

        // Fill A0..A3, immediate swap, reads, write/read, oe gating, high address.
        for (int i = 0; i < 16; i++) begin
            cs = tbl[i].cs; W_req = tbl[i].wr ? `WRITE_ENB : `WRITE_DIS; oe = tbl[i].oe;
            addr = tbl[i].addr; W_data = tbl[i].wdat;
            fill_valid = tbl[i].fv; fill_data = tbl[i].fd; fill_last = tbl[i].fl;
            comp_done = tbl[i].cd;
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.R_data", i),     R_data,           tbl[i].e_rdat);
            chk($sformatf("tbl%0d.fill_ready", i), 32'(fill_ready), 32'(tbl[i].e_frdy));
            chk($sformatf("tbl%0d.comp_valid", i), 32'(comp_valid), 32'(tbl[i].e_cv));
            chk($sformatf("tbl%0d.comp_len", i),   32'(comp_len),   32'(tbl[i].e_len));
            chk($sformatf("tbl%0d.buf_swap", i),   32'(buf_swap),   32'(tbl[i].e_swap));
            chk($sformatf("tbl%0d.oor_err", i),    32'(oor_err),    32'(tbl[i].e_oor));
        end

        // Second fill of 6 words overlapping compute reads; swap waits for comp_done.
        for (int i = 0; i < 6; i++) begin
            rd(i);
            fill_valid = 1'b1; fill_data = vb(i); fill_last = (i == 5);
            cycle("s2_fill");
            if (i <= 3) chk("s2_overlap_rd", R_data, va(i));
        end
        chk("s2_full_ready", 32'(fill_ready), 32'd0);
        idle();
        for (int k = 0; k < 5; k++) begin
            cycle("s2_wait");
            chk("s2_wait_ready", 32'(fill_ready), 32'd0);
            chk("s2_wait_swap", 32'(buf_swap), 32'd0);
        end
        comp_done = 1'b1;
        cycle("s2_done");
        comp_done = 1'b0;
        chk("s2_done_noswap", 32'(buf_swap), 32'd0);
        cycle("s2_swap");
        chk("s2_swap_pulse", 32'(buf_swap), 32'd1);
        chk("s2_len", 32'(comp_len), 32'd6);
        for (int i = 0; i < 6; i++) begin
            rd(i);
            cycle("s2_rd");
            chk("s2_new_rd", R_data, vb(i));
            if (i == 0) chk("s2_swap_once", 32'(buf_swap), 32'd0);
        end

        // Full-depth fill without fill_last.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            fill_valid = 1'b1; fill_data = vc(i);
            cycle("s3_fill");
            if (i == DEPTH - 2) chk("s3_ready_before_last", 32'(fill_ready), 32'd1);
        end
        chk("s3_ready_full", 32'(fill_ready), 32'd0);
        idle();
        comp_done = 1'b1;
        cycle("s3_done");
        comp_done = 1'b0;
        cycle("s3_swap");
        chk("s3_swap_pulse", 32'(buf_swap), 32'd1);
        chk("s3_len", 32'(comp_len), 32'd2048);
        rd(DEPTH - 1);
        cycle("s3_rd_top");
        chk("s3_rd_top", R_data, vc(DEPTH - 1));
        rd(0);
        cycle("s3_rd_bot");
        chk("s3_rd_bot", R_data, vc(0));

        // Reset in the middle of a fill at fill_ptr=3.
        for (int i = 0; i < 3; i++) begin
            idle();
            fill_valid = 1'b1; fill_data = 32'h0BAD_0000 + 32'(i);
            cycle("s4_fill");
        end
        idle();
        do_reset("s4_rst");
        fill_valid = 1'b1; fill_data = 32'h5A5A_0001; fill_last = 1'b1;
        cycle("s4_refill");
        idle();
        cycle("s4_swap");
        chk("s4_swap_pulse", 32'(buf_swap), 32'd1);
        chk("s4_len", 32'(comp_len), 32'd1);
        rd(0);
        cycle("s4_rd0");
        chk("s4_rd0", R_data, 32'h5A5A_0001);

        // Randomized traffic against the model, with one reset in the middle.
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                idle();
                do_reset("rnd_rst");
            end
            cs         = 1'($urandom_range(0, 1));
            W_req      = ($urandom_range(0, 3) == 0) ? `WRITE_ENB : `WRITE_DIS;
            addr       = ($urandom_range(0, 7) == 0) ? 32'(2048 + $urandom_range(0, 15))
                                                     : 32'($urandom_range(0, 15));
            oe         = ($urandom_range(0, 7) != 0);
            W_data     = $urandom;
            fill_valid = 1'($urandom_range(0, 1));
            fill_data  = $urandom;
            fill_last  = ($urandom_range(0, 7) == 0);
            comp_done  = ($urandom_range(0, 9) == 0);
            cycle("rnd");
        end
        idle();
        cycle("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
